// File: rtl/dct2d_pkg.sv
// Shared constants and types for the 8x8 2-D DCT row/column pass scheduler.
package dct2d_pkg;

  localparam int DCT_N = 8;
  localparam int DCT_W = 32;
  localparam int CNT_W = 4;

  typedef logic [DCT_N-1:0][DCT_W-1:0] vec_t;

  typedef enum logic {
    ROW,
    COL
  } state_t;

endpackage

// File: rtl/dct2d_tbuf.sv
// 8x8 transpose buffer: whole-row register writes, combinational whole-column reads.
module dct2d_tbuf
  import dct2d_pkg::*;
#(
  parameter int W = DCT_W,
  parameter int N = DCT_N
) (
  input  logic           clk,
  input  logic           we,
  input  logic [2:0]     waddr,
  input  logic [N*W-1:0] wrow,
  input  logic [2:0]     raddr,
  output logic [N*W-1:0] rcol
);

  logic [N-1:0][N-1:0][W-1:0] mem;
  logic [N-1:0][W-1:0]        wrow_v;
  logic [N-1:0][W-1:0]        rcol_v;

  assign wrow_v = wrow;
  assign rcol   = rcol_v;

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wrow_v;
    end
  end

  always_comb begin
    rcol_v = '0;
    for (int unsigned k = 0; k < N; k++) begin
      rcol_v[k] = mem[k][raddr];
    end
  end

endmodule

// File: rtl/dct2d_pass_scheduler.sv
// Time-shares one 1-D DCT engine between the row pass (input rows -> transpose
// buffer) and the column pass (buffer columns -> quantizer) of an 8x8 2-D DCT.
module dct2d_pass_scheduler
  import dct2d_pkg::*;
#(
  parameter int W = DCT_W,
  parameter int N = DCT_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_row,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_col,
  output logic [2:0]     out_idx,
  output logic           out_last,
  output logic           dct_in_valid,
  input  logic           dct_in_ready,
  output logic [N*W-1:0] dct_in,
  input  logic           dct_out_valid,
  output logic           dct_out_ready,
  input  logic [N*W-1:0] dct_out,
  output logic           busy
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] iss, iss_nx;
  logic [CNT_W-1:0] col, col_nx;
  logic             iss_open;
  logic             col_open;
  logic             buf_we;
  logic [N*W-1:0]   buf_rcol;

  assign iss_open = (iss < CNT_FULL);
  assign col_open = (col < CNT_FULL);

  dct2d_tbuf #(
    .W(W),
    .N(N)
  ) u_tbuf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (col[2:0]),
    .wrow  (dct_out),
    .raddr (iss[2:0]),
    .rcol  (buf_rcol)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ROW;
      iss   <= '0;
      col   <= '0;
    end else begin
      state <= state_nx;
      iss   <= iss_nx;
      col   <= col_nx;
    end
  end

  // Issue (iss) and result (col) counters advance independently each cycle;
  // the pass-completing result overrides both back to zero.
  always_comb begin
    state_nx      = state;
    iss_nx        = iss;
    col_nx        = col;
    buf_we        = 1'b0;
    in_ready      = 1'b0;
    dct_in_valid  = 1'b0;
    dct_in        = in_row;
    dct_out_ready = 1'b1;
    out_valid     = 1'b0;

    case (state)
      ROW: begin
        dct_in_valid = in_valid && iss_open;
        in_ready     = dct_in_ready && iss_open;
        if (in_valid && dct_in_ready && iss_open) begin
          iss_nx = iss + CNT_ONE;
        end
        if (dct_out_valid && col_open) begin
          buf_we = 1'b1;
          col_nx = col + CNT_ONE;
          if (col == CNT_LAST) begin
            state_nx = COL;
            iss_nx   = '0;
            col_nx   = '0;
          end
        end
      end

      COL: begin
        dct_in_valid  = iss_open;
        dct_in        = buf_rcol;
        dct_out_ready = out_ready;
        out_valid     = dct_out_valid;
        if (iss_open && dct_in_ready) begin
          iss_nx = iss + CNT_ONE;
        end
        if (dct_out_valid && out_ready) begin
          col_nx = col + CNT_ONE;
          if (col == CNT_LAST) begin
            state_nx = ROW;
            iss_nx   = '0;
            col_nx   = '0;
          end
        end
      end
    endcase
  end

  assign out_col  = dct_out;
  assign out_idx  = col[2:0];
  assign out_last = (state == COL) && (col == CNT_LAST);
  assign busy     = (iss != '0) || (col != '0) || (state == COL);

endmodule

// File: tb/tb_dct2d_pass_scheduler.sv
// Scoreboard bench for dct2d_pass_scheduler with a randomized in-order engine model.
module tb_dct2d_pass_scheduler;
  import dct2d_pkg::*;

  typedef struct {
    vec_t       col;
    logic [2:0] idx;
    logic       last;
  } exp_t;

  typedef struct {
    vec_t v;
    int   due;
  } eng_t;

  localparam int BOUND = 3000;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, out_last;
  vec_t       in_row, out_col, dct_in, dct_out;
  logic [2:0] out_idx;
  logic       dct_in_valid, dct_in_ready, dct_out_valid, dct_out_ready, busy;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  eng_t eng_q[$];
  vec_t blk[8];

  int eng_lat_lo = 3;
  int eng_lat_hi = 3;
  bit eng_stall = 1'b0;
  int mon_mode = 0;
  int out_cnt = 0;
  int out_done = 0;
  int last_out_cyc = -1;
  int rows_acc = 0;

  int   stall_left = 0;
  int   last_due = 0;
  int   eng_due;
  bit   eng_pend = 1'b0;
  vec_t eng_prev_vec;
  eng_t eng_e;

  int         mcyc = 0;
  bit         mon_pend = 1'b0;
  vec_t       mon_prev_col;
  logic [2:0] mon_prev_idx;
  exp_t       mon_e;

  always #5 clk = ~clk;

  dct2d_pass_scheduler #(
    .W(DCT_W),
    .N(DCT_N)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_row        (in_row),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_col       (out_col),
    .out_idx       (out_idx),
    .out_last      (out_last),
    .dct_in_valid  (dct_in_valid),
    .dct_in_ready  (dct_in_ready),
    .dct_in        (dct_in),
    .dct_out_valid (dct_out_valid),
    .dct_out_ready (dct_out_ready),
    .dct_out       (dct_out),
    .busy          (busy)
  );

  // Engine stub transform: element k is XORed with a per-element constant.
  function automatic logic [31:0] emask(input int k);
    return 32'hA5C3_005A ^ (32'(k) * 32'h0102_0409);
  endfunction

  task automatic check(input string name, input vec_t act, input vec_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %b required %b", name, act, req);
    end
  endtask

  task automatic check_i(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: actual timeout required completion within bound", name);
    finish_sim();
  endtask

  initial begin : watchdog
    #600000;
    timeout("watchdog");
  end

  // Engine model: in-order FIFO, random latency, optional 5-cycle ready stalls.
  initial begin : engine
    dct_in_ready  = 1'b1;
    dct_out_valid = 1'b0;
    dct_out       = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        eng_q.delete();
        stall_left    = 0;
        last_due      = 0;
        dct_in_ready  = 1'b1;
        dct_out_valid = 1'b0;
      end else begin
        if (eng_stall && stall_left == 0 && $urandom_range(0, 7) == 0) stall_left = 5;
        dct_in_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
        if (eng_q.size() > 0 && eng_q[0].due <= cyc) begin
          dct_out_valid = 1'b1;
          dct_out       = eng_q[0].v;
        end else begin
          dct_out_valid = 1'b0;
        end
      end
      #1;
      if (rst) begin
        eng_pend = 1'b0;
      end else begin
        if (eng_pend) begin
          check_b("dct_in_valid_held", dct_in_valid, 1'b1);
          check("dct_in_stable", dct_in, eng_prev_vec);
        end
        eng_pend     = dct_in_valid && !dct_in_ready;
        eng_prev_vec = dct_in;
        if (dct_out_valid && dct_out_ready) void'(eng_q.pop_front());
        if (dct_in_valid && dct_in_ready) begin
          eng_due = cyc + int'($urandom_range(eng_lat_lo, eng_lat_hi));
          if (eng_due < last_due) eng_due = last_due;
          last_due = eng_due;
          for (int k = 0; k < 8; k++) eng_e.v[k] = dct_in[k] ^ emask(k);
          eng_e.due = eng_due;
          eng_q.push_back(eng_e);
        end
      end
    end
  end

  initial begin : monitor
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      out_done = out_cnt;
      mcyc++;
      case (mon_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = ((mcyc % 4) == 0) || ((mcyc % 4) == 3);
      endcase
      #1;
      if (rst) begin
        mon_pend = 1'b0;
      end else begin
        if (mon_pend) begin
          check_b("out_valid_held", out_valid, 1'b1);
          check("out_col_stable", out_col, mon_prev_col);
          check_i("out_idx_stable", int'(out_idx), int'(mon_prev_idx));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: actual idx %0d required no output", out_idx);
          end else begin
            mon_e = exp_q.pop_front();
            check("out_col", out_col, mon_e.col);
            check_i("out_idx", int'(out_idx), int'(mon_e.idx));
            check_b("out_last", out_last, mon_e.last);
            if (mon_e.last) last_out_cyc = cyc;
          end
          out_cnt++;
        end
        mon_pend     = out_valid && !out_ready;
        mon_prev_col = out_col;
        mon_prev_idx = out_idx;
      end
    end
  end

  task automatic gen_rows(input bit ramp);
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++)
        blk[r][k] = ramp ? 32'(8 * r + k) : $urandom();
  endtask

  // Reference: 2-D result is the engine map applied along rows, then columns.
  task automatic push_expected();
    exp_t e;
    for (int j = 0; j < 8; j++) begin
      for (int k = 0; k < 8; k++) e.col[k] = blk[k][j] ^ emask(j) ^ emask(k);
      e.idx  = 3'(j);
      e.last = (j == 7);
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_rows(input bit gaps, output int first_cyc);
    int waited;
    int n;
    first_cyc = -1;
    for (int r = 0; r < 8; r++) begin
      if (gaps) begin
        n = $urandom_range(0, 2);
        repeat (n) begin
          @(negedge clk);
          in_valid = 1'b0;
          for (int k = 0; k < 8; k++) in_row[k] = $urandom();
        end
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_row   = blk[r];
      waited   = 0;
      forever begin
        #1;
        if ((rows_acc % 8) == 0 && out_done < rows_acc)
          check_b("in_ready_blocked", in_ready, 1'b0);
        else
          check_b("in_ready_open", in_ready, dct_in_ready);
        if (in_valid && in_ready) break;
        waited++;
        if (waited > BOUND) timeout("row_accept");
        @(negedge clk);
      end
      rows_acc++;
      if (r == 0) first_cyc = cyc;
    end
  endtask

  task automatic wait_drain();
    int waited;
    waited = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      #2;
      waited++;
      if (waited > 4 * BOUND) timeout("drain");
    end
    repeat (2) @(negedge clk);
    #1;
    check_b("idle_busy", busy, 1'b0);
  endtask

  task automatic end_rows();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin : main
    int fa, fb, target, waited;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_row   = '0;
    repeat (3) @(negedge clk);
    #1;
    check_b("rst_out_valid", out_valid, 1'b0);
    check_b("rst_out_last", out_last, 1'b0);
    check_b("rst_busy", busy, 1'b0);
    check_b("rst_dct_out_ready", dct_out_ready, 1'b1);
    check_b("rst_in_ready", in_ready, dct_in_ready);
    #1 rst = 1'b0;

    // Single ramp block, L=3, no stalls.
    gen_rows(1'b1); push_expected(); drive_rows(1'b0, fa); end_rows(); wait_drain();

    // Back-to-back blocks with in_valid held high.
    gen_rows(1'b0); push_expected(); drive_rows(1'b0, fa);
    gen_rows(1'b0); push_expected(); drive_rows(1'b0, fb);
    check_i("b2b_first_row", fb, last_out_cyc + 1);
    check_i("block_period", fb - fa, 16 + 2 * 3);
    end_rows(); wait_drain();

    // out_ready 1-0-0-1 pattern during the column pass.
    mon_mode = 2;
    repeat (2) begin gen_rows(1'b0); push_expected(); drive_rows(1'b0, fa); end
    end_rows(); wait_drain();
    mon_mode = 0;

    // Engine input stalls of 5 cycles in both passes.
    eng_stall = 1'b1;
    repeat (2) begin gen_rows(1'b0); push_expected(); drive_rows(1'b0, fa); end
    end_rows(); wait_drain();
    eng_stall = 1'b0;

    // Reset after four column outputs of a block.
    gen_rows(1'b0); push_expected(); drive_rows(1'b0, fa); end_rows();
    target = rows_acc - 4;
    waited = 0;
    do begin
      @(negedge clk);
      #2;
      waited++;
      if (waited > BOUND) timeout("mid_col_wait");
    end while (out_done < target);
    check_b("busy_mid_col", busy, 1'b1);
    rst = 1'b1;
    #1;
    check_b("midrst_busy", busy, 1'b0);
    check_b("midrst_out_valid", out_valid, 1'b0);
    check_b("midrst_out_last", out_last, 1'b0);
    exp_q.delete();
    rows_acc = 0;
    out_cnt  = 0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    gen_rows(1'b0); push_expected(); drive_rows(1'b0, fa); end_rows(); wait_drain();

    // Random gaps, latency 1..6, stalls, random out_ready.
    eng_lat_lo = 1;
    eng_lat_hi = 6;
    eng_stall  = 1'b1;
    mon_mode   = 1;
    for (int b = 0; b < 20; b++) begin
      gen_rows(1'b0); push_expected(); drive_rows(1'b1, fa);
    end
    end_rows(); wait_drain();

    finish_sim();
  end

endmodule
